triangle_assembler: RTL and testbench

//  Sits directly downstream of vertex_rasterize and consumes its rast_pt/rast_pt_valid stream.

---
 rtl/triangle_assembler_pkg.sv | 53 +++++
 rtl/triangle_assembler_tri_fifo.sv | 54 +++++
 rtl/triangle_assembler.sv | 179 +++++++++++++++++
 tb/tb_triangle_assembler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_assembler_pkg.sv
// Shared types for the triangle assembler: vertex, triangle, bounding box and FIFO entry.
// Also holds the small min/max/clamp helpers used by the geometry stages.
package triangle_assembler_pkg;

    localparam int COORD_W = 13;
    localparam int DELTA_W = 14;
    localparam int AREA_W  = 28;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [DELTA_W-1:0] delta_t;
    typedef logic signed [AREA_W-1:0]  area_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } vec3_i13;

    // Index 0 is the first vertex to arrive.
    typedef vec3_i13 [2:0] tri_i13;

    typedef struct packed {
        coord_t min_x;
        coord_t min_y;
        coord_t max_x;
        coord_t max_y;
    } bbox_i13;

    typedef struct packed {
        tri_i13  verts;
        bbox_i13 bbox;
        area_t   area2;
    } tri_entry_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic coord_t clamp(input coord_t v, input coord_t hi);
        if (v < 0) return '0;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/triangle_assembler_tri_fifo.sv
// First-word-fall-through FIFO of assembled triangles.
// The head reads as zero whenever the FIFO is empty.
module tri_fifo
    import triangle_assembler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tri_entry_t push_data,
    input  logic       pop,
    output tri_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    tri_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/triangle_assembler.sv
// Groups raster vertices into triangles, computes signed twice-area and clamped bbox,
// culls degenerate/off-screen/back-facing triangles and buffers survivors in a FIFO.
module triangle_assembler
    import triangle_assembler_pkg::*;
#(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int FIFO_DEPTH = 4,
    parameter bit CULL_BACK  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  vec3_i13     rast_pt,
    input  logic        rast_pt_valid,
    input  logic        tri_restart,
    output tri_i13      tri_out,
    output bbox_i13     bbox_out,
    output area_t       tri_area2,
    output logic        tri_valid,
    input  logic        tri_ready,
    output logic        overflow,
    output logic [15:0] cull_count
);

    localparam coord_t X_MAX = coord_t'(IMG_W - 1);
    localparam coord_t Y_MAX = coord_t'(IMG_H - 1);

    logic [1:0] vtx_cnt;
    vec3_i13    v0;
    vec3_i13    v1;
    logic       launch;

    logic   s1_valid;
    tri_i13 s1_tri;
    delta_t s1_dx1;
    delta_t s1_dy1;
    delta_t s1_dx2;
    delta_t s1_dy2;
    coord_t s1_min_x;
    coord_t s1_min_y;
    coord_t s1_max_x;
    coord_t s1_max_y;

    area_t   s1_area;
    bbox_i13 s1_bbox;
    logic    s1_cull;

    logic       s2_valid;
    logic       s2_cull;
    tri_entry_t s2_entry;

    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    tri_entry_t head;

    // A restart coinciding with a vertex makes that vertex the new v0.
    assign launch = rast_pt_valid && !tri_restart && (vtx_cnt == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vtx_cnt <= '0;
            v0      <= '0;
            v1      <= '0;
        end else if (rast_pt_valid) begin
            if (tri_restart) begin
                v0      <= rast_pt;
                vtx_cnt <= 2'd1;
            end else begin
                case (vtx_cnt)
                    2'd0: begin
                        v0      <= rast_pt;
                        vtx_cnt <= 2'd1;
                    end
                    2'd1: begin
                        v1      <= rast_pt;
                        vtx_cnt <= 2'd2;
                    end
                    default: vtx_cnt <= 2'd0;
                endcase
            end
        end else if (tri_restart) begin
            vtx_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tri   <= '0;
            s1_dx1   <= '0;
            s1_dy1   <= '0;
            s1_dx2   <= '0;
            s1_dy2   <= '0;
            s1_min_x <= '0;
            s1_min_y <= '0;
            s1_max_x <= '0;
            s1_max_y <= '0;
        end else begin
            s1_valid <= launch;
            if (launch) begin
                s1_tri[0] <= v0;
                s1_tri[1] <= v1;
                s1_tri[2] <= rast_pt;
                s1_dx1    <= delta_t'(v1.x) - delta_t'(v0.x);
                s1_dy1    <= delta_t'(v1.y) - delta_t'(v0.y);
                s1_dx2    <= delta_t'(rast_pt.x) - delta_t'(v0.x);
                s1_dy2    <= delta_t'(rast_pt.y) - delta_t'(v0.y);
                s1_min_x  <= min3(v0.x, v1.x, rast_pt.x);
                s1_min_y  <= min3(v0.y, v1.y, rast_pt.y);
                s1_max_x  <= max3(v0.x, v1.x, rast_pt.x);
                s1_max_y  <= max3(v0.y, v1.y, rast_pt.y);
            end
        end
    end

    // 14-bit deltas give products under 2^26, so the 28-bit difference is exact.
    assign s1_area = area_t'(s1_dx1) * area_t'(s1_dy2) - area_t'(s1_dx2) * area_t'(s1_dy1);

    assign s1_bbox.min_x = clamp(s1_min_x, X_MAX);
    assign s1_bbox.min_y = clamp(s1_min_y, Y_MAX);
    assign s1_bbox.max_x = clamp(s1_max_x, X_MAX);
    assign s1_bbox.max_y = clamp(s1_max_y, Y_MAX);

    // Off-screen tests use the unclamped extents.
    assign s1_cull = (s1_area == '0)
                   || (s1_max_x < 0) || (s1_min_x > X_MAX)
                   || (s1_max_y < 0) || (s1_min_y > Y_MAX)
                   || (CULL_BACK && (s1_area < 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_cull  <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cull        <= s1_cull;
                s2_entry.verts <= s1_tri;
                s2_entry.bbox  <= s1_bbox;
                s2_entry.area2 <= s1_area;
            end
        end
    end

    assign push = s2_valid && !s2_cull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            cull_count <= '0;
        end else begin
            if (s2_valid && s2_cull && (cull_count != 16'hFFFF))
                cull_count <= cull_count + 16'd1;
            if (push && fifo_full && !(tri_ready && !fifo_empty))
                overflow <= 1'b1;
        end
    end

    tri_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s2_entry),
        .pop       (tri_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tri_valid = !fifo_empty;
    assign tri_out   = head.verts;
    assign bbox_out  = head.bbox;
    assign tri_area2 = head.area2;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: vector table plus restart, FIFO, reset and back-face sequences.
module tb_triangle_assembler;
    import triangle_assembler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    vec3_i13     rast_pt;
    logic        rast_pt_valid;
    logic        tri_restart;
    tri_i13      tri_out;
    bbox_i13     bbox_out;
    area_t       tri_area2;
    logic        tri_valid;
    logic        tri_ready;
    logic        overflow;
    logic [15:0] cull_count;

    vec3_i13     cb_pt;
    logic        cb_pt_valid;
    tri_i13      cb_tri;
    bbox_i13     cb_bbox;
    area_t       cb_area2;
    logic        cb_valid;
    logic        cb_overflow;
    logic [15:0] cb_cull;

    always #5 clk = ~clk;

    triangle_assembler #(.IMG_W(512), .IMG_H(512), .FIFO_DEPTH(4), .CULL_BACK(1'b0)) dut (
        .clk(clk), .rst(rst), .rast_pt(rast_pt), .rast_pt_valid(rast_pt_valid),
        .tri_restart(tri_restart), .tri_out(tri_out), .bbox_out(bbox_out),
        .tri_area2(tri_area2), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .overflow(overflow), .cull_count(cull_count)
    );

    triangle_assembler #(.IMG_W(512), .IMG_H(512), .FIFO_DEPTH(4), .CULL_BACK(1'b1)) dut_cb (
        .clk(clk), .rst(rst), .rast_pt(cb_pt), .rast_pt_valid(cb_pt_valid),
        .tri_restart(1'b0), .tri_out(cb_tri), .bbox_out(cb_bbox),
        .tri_area2(cb_area2), .tri_valid(cb_valid), .tri_ready(1'b1),
        .overflow(cb_overflow), .cull_count(cb_cull)
    );

    typedef struct {
        vec3_i13 a;
        vec3_i13 b;
        vec3_i13 c;
        logic    cull;
        area_t   area;
        bbox_i13 bb;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec3_i13 pt(input int x, input int y, input int z);
        vec3_i13 p;
        p.x = coord_t'(x);
        p.y = coord_t'(y);
        p.z = coord_t'(z);
        return p;
    endfunction

    function automatic bbox_i13 box(input int x0, input int y0, input int x1, input int y1);
        bbox_i13 b;
        b.min_x = coord_t'(x0);
        b.min_y = coord_t'(y0);
        b.max_x = coord_t'(x1);
        b.max_y = coord_t'(y1);
        return b;
    endfunction

    function automatic vec_t mk(input int ax, input int ay, input int bx, input int by,
                                input int cx, input int cy, input int z, input logic cull,
                                input int area, input bbox_i13 bb);
        vec_t v;
        v.a    = pt(ax, ay, z);
        v.b    = pt(bx, by, z + 1);
        v.c    = pt(cx, cy, z + 2);
        v.cull = cull;
        v.area = area_t'(area);
        v.bb   = bb;
        return v;
    endfunction

    function automatic tri_i13 mk_tri(input vec3_i13 a, input vec3_i13 b, input vec3_i13 c);
        tri_i13 t;
        t[0] = a;
        t[1] = b;
        t[2] = c;
        return t;
    endfunction

    // Called at a falling edge; returns at the falling edge after the third vertex.
    task automatic send_tri(input vec3_i13 a, input vec3_i13 b, input vec3_i13 c);
        rast_pt_valid = 1'b1;
        rast_pt = a;
        @(negedge clk);
        rast_pt = b;
        @(negedge clk);
        rast_pt = c;
        @(negedge clk);
        rast_pt_valid = 1'b0;
    endtask

    int      exp_cull;
    int      seen;
    int      k;
    int      drain_exp [4];
    vec3_i13 va, vb, vc;

    initial begin
        vecs[0] = mk(10, 10, 50, 10, 10, 40, 1, 1'b0, 1200, box(10, 10, 50, 40));
        vecs[1] = mk(0, 0, 5, 5, 10, 10, 4, 1'b1, 0, box(0, 0, 10, 10));
        vecs[2] = mk(-20, -20, 600, 0, 0, 600, 7, 1'b0, 384000, box(0, 0, 511, 511));
        vecs[3] = mk(600, 600, 700, 600, 600, 700, 10, 1'b1, 10000, box(511, 511, 511, 511));
        vecs[4] = mk(10, 10, 10, 40, 50, 10, 13, 1'b0, -1200, box(10, 10, 50, 40));
        vecs[5] = mk(-4096, -4096, 4095, -4096, -4096, 4095, 16, 1'b0, 67092481, box(0, 0, 511, 511));
        vecs[6] = mk(-10, 5, -1, 5, -5, 20, 19, 1'b1, 135, box(0, 5, 0, 20));
        vecs[7] = mk(511, 0, 511, 10, 600, 5, 22, 1'b0, -890, box(511, 0, 511, 10));
        vecs[8] = mk(512, 0, 520, 0, 512, 9, 25, 1'b1, 72, box(511, 0, 511, 9));
        drain_exp = '{1, 2, 3, 4};

        rst = 1'b1;
        rast_pt = '0;
        rast_pt_valid = 1'b0;
        tri_restart = 1'b0;
        tri_ready = 1'b1;
        cb_pt = '0;
        cb_pt_valid = 1'b0;
        #3;
        check("reset tri_valid", tri_valid, 1'b0);
        check("reset overflow", overflow, 1'b0);
        check("reset cull_count", cull_count, 16'd0);
        check("reset area", tri_area2, area_t'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        exp_cull = 0;
        for (int i = 0; i < NVEC; i++) begin
            send_tri(vecs[i].a, vecs[i].b, vecs[i].c);
            @(negedge clk);
            check($sformatf("vec%0d early valid", i), tri_valid, 1'b0);
            @(negedge clk);
            if (vecs[i].cull) exp_cull++;
            check($sformatf("vec%0d valid", i), tri_valid, !vecs[i].cull);
            if (!vecs[i].cull) begin
                check($sformatf("vec%0d area", i), tri_area2, vecs[i].area);
                check($sformatf("vec%0d bbox", i), bbox_out, vecs[i].bb);
                check($sformatf("vec%0d verts", i), tri_out, mk_tri(vecs[i].a, vecs[i].b, vecs[i].c));
            end
            check($sformatf("vec%0d cull_count", i), cull_count, 16'(exp_cull));
        end

        // Two stray vertices, a lone restart, then a full triangle.
        rast_pt_valid = 1'b1;
        rast_pt = pt(100, 100, 0);
        @(negedge clk);
        rast_pt = pt(200, 100, 0);
        @(negedge clk);
        rast_pt_valid = 1'b0;
        tri_restart = 1'b1;
        @(negedge clk);
        tri_restart = 1'b0;
        send_tri(vecs[0].a, vecs[0].b, vecs[0].c);
        @(negedge clk);
        @(negedge clk);
        check("restart valid", tri_valid, 1'b1);
        check("restart area", tri_area2, area_t'(1200));
        check("restart verts", tri_out, mk_tri(vecs[0].a, vecs[0].b, vecs[0].c));
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (tri_valid) seen++;
        end
        check("restart extra tris", seen, 0);

        // Restart coinciding with a vertex keeps that vertex as v0.
        rast_pt_valid = 1'b1;
        rast_pt = pt(100, 100, 0);
        @(negedge clk);
        tri_restart = 1'b1;
        rast_pt = vecs[0].a;
        @(negedge clk);
        tri_restart = 1'b0;
        rast_pt = vecs[0].b;
        @(negedge clk);
        rast_pt = vecs[0].c;
        @(negedge clk);
        rast_pt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("restart+vtx valid", tri_valid, 1'b1);
        check("restart+vtx area", tri_area2, area_t'(1200));
        @(negedge clk);

        // FIFO fill, push-while-full with a pop, then a real drop.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tri_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            va = vecs[0].a; va.z = coord_t'(t);
            vb = vecs[0].b;
            vc = vecs[0].c;
            send_tri(va, vb, vc);
        end
        @(negedge clk);
        tri_ready = 1'b1;
        @(negedge clk);
        tri_ready = 1'b0;
        check("full push+pop overflow", overflow, 1'b0);
        check("full push+pop head", tri_out[0].z, coord_t'(1));
        va = vecs[0].a; va.z = coord_t'(5);
        send_tri(va, vecs[0].b, vecs[0].c);
        @(negedge clk);
        @(negedge clk);
        check("drop overflow", overflow, 1'b1);
        check("drop cull_count", cull_count, 16'd0);
        check("stalled head", tri_out[0].z, coord_t'(1));
        check("stalled valid", tri_valid, 1'b1);

        tri_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (tri_valid) begin
                if (k < 4) check($sformatf("drain %0d", k), tri_out[0].z, coord_t'(drain_exp[k]));
                k++;
            end
            @(negedge clk);
        end
        check("drain count", k, 4);

        // Asynchronous reset with data in flight.
        tri_ready = 1'b0;
        send_tri(vecs[1].a, vecs[1].b, vecs[1].c);
        send_tri(vecs[0].a, vecs[0].b, vecs[0].c);
        @(negedge clk);
        @(negedge clk);
        check("pre-rst valid", tri_valid, 1'b1);
        check("pre-rst cull_count", cull_count, 16'd1);
        rast_pt_valid = 1'b1;
        rast_pt = vecs[0].a;
        @(negedge clk);
        rast_pt = vecs[0].b;
        @(negedge clk);
        rast_pt = vecs[0].c;
        #2 rst = 1'b1;
        #1;
        check("mid rst valid", tri_valid, 1'b0);
        check("mid rst overflow", overflow, 1'b0);
        check("mid rst cull_count", cull_count, 16'd0);
        check("mid rst area", tri_area2, area_t'(0));
        check("mid rst bbox", bbox_out, bbox_i13'(0));
        check("mid rst verts", tri_out, tri_i13'(0));
        @(negedge clk);
        rst = 1'b0;
        rast_pt_valid = 1'b0;
        tri_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (tri_valid) seen++;
        end
        check("post rst empty", seen, 0);

        // Back-face culling instance: clockwise culled, counter-clockwise kept.
        cb_pt_valid = 1'b1;
        cb_pt = pt(10, 10, 0);
        @(negedge clk);
        cb_pt = pt(10, 40, 0);
        @(negedge clk);
        cb_pt = pt(50, 10, 0);
        @(negedge clk);
        cb_pt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("cw valid", cb_valid, 1'b0);
        check("cw cull_count", cb_cull, 16'd1);
        cb_pt_valid = 1'b1;
        cb_pt = pt(10, 10, 0);
        @(negedge clk);
        cb_pt = pt(50, 10, 0);
        @(negedge clk);
        cb_pt = pt(10, 40, 0);
        @(negedge clk);
        cb_pt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ccw valid", cb_valid, 1'b1);
        check("ccw area", cb_area2, area_t'(1200));
        check("ccw bbox", cb_bbox, box(10, 10, 50, 40));
        check("ccw verts", cb_tri, mk_tri(pt(10, 10, 0), pt(50, 10, 0), pt(10, 40, 0)));
        check("ccw cull_count", cb_cull, 16'd1);
        check("cb overflow", cb_overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
